mem_responder: RTL and testbench
================================

// Module: mem_responder
// PURPOSE
//   Memory-side responder for the single-cycle core's data port (ALU result = addr,
//   Datawr, MemOp, MemWr). Owns a word-addressed RAM. Serves one request at a time
//   over a valid/ready request channel and a valid/ready response channel.
//   Applies RISC-V byte/half/word store merge, load extract and sign/zero extension
//   inside the block. Emulates a configurable access latency.
// PARAMETERS
//   DEPTH      4096           RAM depth in 32-bit words
//   BASE_ADDR  32'h8000_0000  byte address of word 0
//   LATENCY    2              extra wait cycles before response (0..15)
// PORTS
//   clk         in   1   clock, all state updates on rising edge
//   rst         in   1   synchronous, active-high reset
//   req_valid   in   1   request present
//   req_ready   out  1   responder can accept; equals (state==IDLE)
//   req_addr    in   32  byte address
//   req_wdata   in   32  store data; low bytes used for SB/SH
//   req_memop   in   3   funct3 encoding, see package
//   req_wen     in   1   1=store, 0=load
//   resp_valid  out  1   response present
//   resp_ready  in   1   consumer accepts response
//   resp_rdata  out  32  extended load data; 0 for stores and errors
//   resp_err    out  1   misaligned, out-of-range or illegal memop
// BEHAVIOUR
//   Reset: state=IDLE, resp_valid=0, resp_rdata=0, resp_err=0, counter=0.
//     RAM contents are not reset. A reset during WAIT aborts the request.
//     An uncommitted store is discarded.
//   FSM: IDLE -> (req_valid&req_ready) -> WAIT, counter=LATENCY.
//     WAIT: counter decrements each cycle. At counter==0 commit -> RESP.
//     With LATENCY=0 the commit happens in the first WAIT cycle.
//     RESP: hold resp_* stable until resp_ready=1, then go to IDLE.
//   Latency: resp_valid rises exactly LATENCY+1 cycles after the accept edge.
//   Throughput: one outstanding request; req_ready=0 in WAIT and RESP.
//     A held req_valid is accepted only after return to IDLE.
//   Latch: addr/wdata/memop/wen are captured at accept. Later port changes are ignored.
//   Commit, on the edge entering RESP:
//     Error check first. Any of these gives resp_err=1, resp_rdata=0 and no RAM write:
//       - (addr-BASE_ADDR) >= DEPTH*4 (unsigned, so wrap below base is out of range)
//       - half access with addr[0]!=0
//       - word access with addr[1:0]!=0
//       - memop in {011,110,111}
//       - store with memop in {100,101}
//     Index = (addr-BASE_ADDR)>>2.
//     Store SB: lane addr[1:0] <= wdata[7:0].
//     Store SH: lanes {addr[1],0}..+1 <= wdata[15:0].
//     Store SW: full word. Other lanes are preserved (read-modify-write in one cycle).
//       resp_rdata=0, resp_err=0.
//     Load reads the array value at commit.
//       LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
//   Ordering: a store is visible to every request accepted after its response handshake.
//   Simultaneous resp handshake and req_valid in the same cycle: the new request
//     is not accepted until the following (IDLE) cycle.
// STRUCTURE
//   Shared package mem_pkg: MEMOP_B=3'b000, MEMOP_H=3'b001, MEMOP_W=3'b010,
//     MEMOP_BU=3'b100, MEMOP_HU=3'b101, FSM state encodings IDLE/WAIT/RESP.
//     The same package is used by IDU_ysyx.
//   Sub-module mem_lane_fmt (combinational): inputs are addr[1:0], memop, old word
//     and wdata. Outputs are the merged store word, the extended load data and the
//     misalign flag.
//   Top: FSM, latency counter, request latch, RAM array, range check.
// TESTING (LATENCY=2 unless noted)
//   1 rst=1 for 2 cycles -> resp_valid=0, resp_err=0, rdata=0; req_ready=1 on first cycle after release.
//   2 SW 0x8000_0000<=0xDEADBEEF, then LW same -> resp_valid 3 cycles after each accept;
//     rdata=0xDEADBEEF, err=0. Repeat with LATENCY=0 -> 1 cycle.
//   3 SB 0x8000_0001<=0x12 -> LW=0xDEAD12EF; LB 0x8000_0003=0xFFFFFFDE;
//     LBU=0x000000DE; LH 0x8000_0002=0xFFFFDEAD; LHU=0x0000DEAD.
//   4 LW 0x8000_0002 and SH 0x8000_0003 -> err=1, rdata=0; following LW 0x8000_0000 unchanged.
//     LW 0x7FFF_FFFC and memop=3'b011 -> err=1.
//   5 resp_ready=0 for 5 cycles with req_valid=1 -> resp_valid/rdata/err stable, req_ready=0,
//     no second accept. Accept occurs the cycle after the handshake.
//   6 rst pulsed during WAIT of SW 0x8000_0010<=0x55 -> no response; later LW 0x8000_0010
//     returns the prior value.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: memop encodings, FSM states and request record shared by the memory responder and IDU_ysyx
package mem_pkg;
  localparam logic [2:0] MEMOP_B  = 3'b000;
  localparam logic [2:0] MEMOP_H  = 3'b001;
  localparam logic [2:0] MEMOP_W  = 3'b010;
  localparam logic [2:0] MEMOP_BU = 3'b100;
  localparam logic [2:0] MEMOP_HU = 3'b101;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  memop;
    logic        wen;
  } mem_req_t;
  // Stores only exist as B/H/W; unsigned variants are load-only.
  function automatic logic memop_ok(input logic [2:0] op, input logic wen);
    return (op == MEMOP_B) || (op == MEMOP_H) || (op == MEMOP_W) ||
           (!wen && ((op == MEMOP_BU) || (op == MEMOP_HU)));
  endfunction
endpackage

// File: rtl/mem_responder_if.sv
// mem_responder_if: valid/ready request + response channels between core (master) and responder (slave)
//   req_*  : request valid/ready, byte address, store data, funct3 memop, write enable
//   resp_* : response valid/ready, extended load data, error flag
interface mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_memop;
  logic        req_wen;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  modport master (
    output req_valid, req_addr, req_wdata, req_memop, req_wen, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );
  modport slave (
    input  req_valid, req_addr, req_wdata, req_memop, req_wen, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/mem_lane_fmt.sv
// mem_lane_fmt: byte-lane store merge, load extract/extend and misalignment detect
//   addr_lo : byte offset within the word      memop : funct3 access type
//   old_word: current RAM word                  wdata : store data (low bytes for SB/SH)
//   st_word : merged word to write back         ld_data: extended load result
//   misalign: half not 2-aligned or word not 4-aligned
module mem_lane_fmt
  import mem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  memop,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  output logic [31:0] st_word,
  output logic [31:0] ld_data,
  output logic        misalign
);
  logic [1:0]  size;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] mask;
  logic [31:0] wrep;
  // memop[1:0] is the access size: 00 byte, 01 half, 10 word.
  assign size = memop[1:0];
  assign misalign = (size == 2'b01 && addr_lo[0]) || (size == 2'b10 && addr_lo != 2'b00);
  assign ld_byte = 8'(old_word >> {addr_lo, 3'b000});
  assign ld_half = 16'(old_word >> {addr_lo[1], 4'b0000});
  always_comb begin
    ld_data = memop == MEMOP_B  ? {{24{ld_byte[7]}}, ld_byte} :
              memop == MEMOP_BU ? {24'h0, ld_byte} :
              memop == MEMOP_H  ? {{16{ld_half[15]}}, ld_half} :
              memop == MEMOP_HU ? {16'h0, ld_half} : old_word;
  end
  // Replicate the store data across all lanes and let the mask pick the target lanes.
  always_comb begin
    mask = size == 2'b00 ? 32'h0000_00FF << {addr_lo, 3'b000} :
           size == 2'b01 ? 32'h0000_FFFF << {addr_lo[1], 4'b0000} : 32'hFFFF_FFFF;
    wrep = size == 2'b00 ? {4{wdata[7:0]}} :
           size == 2'b01 ? {2{wdata[15:0]}} : wdata;
    st_word = (old_word & ~mask) | (wrep & mask);
  end
endmodule

// File: rtl/mem_responder.sv
// mem_responder: word-addressed RAM serving one load/store at a time with emulated latency
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of mem_responder_if (request and response channels)
module mem_responder
  import mem_pkg::*;
#(
  parameter int          DEPTH     = 4096,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          LATENCY   = 2
) (
  input logic            clk,
  input logic            rst,
  mem_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [32:0] SPAN = 33'(DEPTH) << 2;
  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  mem_req_t    req_q, req_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [31:0] mem [DEPTH];
  logic [31:0] offset;
  logic [AW-1:0] idx;
  logic [31:0] old_word, st_word, ld_data;
  logic        misalign, err, commit;
  // Unsigned offset makes addresses below the base wrap to huge values and fail the range check.
  assign offset   = req_q.addr - BASE_ADDR;
  assign idx      = offset[AW+1:2];
  assign old_word = mem[idx];
  assign err      = ({1'b0, offset} >= SPAN) || misalign || !memop_ok(req_q.memop, req_q.wen);
  assign commit   = state_q == ST_WAIT && cnt_q == 4'd0;
  mem_lane_fmt u_fmt (
    .addr_lo (req_q.addr[1:0]),
    .memop   (req_q.memop),
    .old_word(old_word),
    .wdata   (req_q.wdata),
    .st_word (st_word),
    .ld_data (ld_data),
    .misalign(misalign)
  );
  assign bus.req_ready  = state_q == ST_IDLE;
  assign bus.resp_valid = state_q == ST_RESP;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    if (state_q == ST_IDLE && bus.req_valid) begin
      state_d = ST_WAIT;
      cnt_d   = 4'(LATENCY);
      req_d   = {bus.req_addr, bus.req_wdata, bus.req_memop, bus.req_wen};
    end else if (commit) begin
      state_d = ST_RESP;
      rdata_d = (err || req_q.wen) ? 32'h0 : ld_data;
      err_d   = err;
    end else if (state_q == ST_WAIT) begin
      cnt_d = cnt_q - 4'd1;
    end else if (state_q == ST_RESP && bus.resp_ready) begin
      state_d = ST_IDLE;
      rdata_d = 32'h0;
      err_d   = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      req_q   <= '0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end
  // RAM is not reset; a reset before commit drops the pending store.
  always_ff @(posedge clk) begin
    if (!rst && commit && req_q.wen && !err) mem[idx] <= st_word;
  end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed checks of the memory responder at LATENCY=2 and LATENCY=0
module tb_mem_responder;
  import mem_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [31:0] a = '0, wd = '0;
  logic [2:0]  op = '0;
  logic        we = 1'b0;
  logic        v2 = 1'b0, v0 = 1'b0, rr2 = 1'b0, rr0 = 1'b0;
  mem_responder_if bus ();
  mem_responder_if bus0 ();
  assign bus.req_valid  = v2;
  assign bus.req_addr   = a;
  assign bus.req_wdata  = wd;
  assign bus.req_memop  = op;
  assign bus.req_wen    = we;
  assign bus.resp_ready = rr2;
  assign bus0.req_valid  = v0;
  assign bus0.req_addr   = a;
  assign bus0.req_wdata  = wd;
  assign bus0.req_memop  = op;
  assign bus0.req_wen    = we;
  assign bus0.resp_ready = rr0;
  mem_responder #(.LATENCY(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  mem_responder #(.LATENCY(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  int n_chk = 0, n_pass = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  // One full transaction; port fields are scrambled after accept to exercise the request latch.
  task automatic txn(input bit sel, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [2:0] memop, input logic wen,
                     output logic [31:0] rd, output logic er, output int lat);
    int k;
    a = addr; wd = wdata; op = memop; we = wen;
    if (sel) v0 = 1'b1; else v2 = 1'b1;
    k = 0;
    while (!(sel ? bus0.req_ready : bus.req_ready) && k < 20) begin step(); k++; end
    if (k == 20) check("accept_timeout", 0, 1);
    step();
    v0 = 1'b0; v2 = 1'b0;
    a = ~addr; wd = ~wdata; op = 3'b111; we = ~wen;
    lat = 0;
    while (!(sel ? bus0.resp_valid : bus.resp_valid) && lat < 30) begin step(); lat++; end
    rd = sel ? bus0.resp_rdata : bus.resp_rdata;
    er = sel ? bus0.resp_err : bus.resp_err;
    if (sel) rr0 = 1'b1; else rr2 = 1'b1;
    step();
    rr0 = 1'b0; rr2 = 1'b0;
  endtask
  logic [31:0] rd;
  logic        er;
  int          lat;
  initial begin
    step();
    step();
    check("rst_resp_valid", 32'(bus.resp_valid), 0);
    check("rst_resp_err", 32'(bus.resp_err), 0);
    check("rst_rdata", bus.resp_rdata, 0);
    rst = 1'b0;
    step();
    check("rst_req_ready", 32'(bus.req_ready), 1);
    txn(0, 32'h8000_0000, 32'hDEAD_BEEF, MEMOP_W, 1, rd, er, lat);
    check("sw_lat", lat, 3);
    check("sw_rdata", rd, 0);
    check("sw_err", 32'(er), 0);
    txn(0, 32'h8000_0000, 0, MEMOP_W, 0, rd, er, lat);
    check("lw_lat", lat, 3);
    check("lw_rdata", rd, 32'hDEAD_BEEF);
    check("lw_err", 32'(er), 0);
    txn(1, 32'h8000_0000, 32'hDEAD_BEEF, MEMOP_W, 1, rd, er, lat);
    check("sw_lat0", lat, 1);
    txn(1, 32'h8000_0000, 0, MEMOP_W, 0, rd, er, lat);
    check("lw_lat0", lat, 1);
    check("lw_rdata0", rd, 32'hDEAD_BEEF);
    txn(0, 32'h8000_0001, 32'hAABB_CC12, MEMOP_B, 1, rd, er, lat);
    check("sb_err", 32'(er), 0);
    txn(0, 32'h8000_0000, 0, MEMOP_W, 0, rd, er, lat);
    check("sb_lw", rd, 32'hDEAD_12EF);
    txn(0, 32'h8000_0003, 0, MEMOP_B, 0, rd, er, lat);
    check("lb", rd, 32'hFFFF_FFDE);
    txn(0, 32'h8000_0003, 0, MEMOP_BU, 0, rd, er, lat);
    check("lbu", rd, 32'h0000_00DE);
    txn(0, 32'h8000_0002, 0, MEMOP_H, 0, rd, er, lat);
    check("lh", rd, 32'hFFFF_DEAD);
    txn(0, 32'h8000_0002, 0, MEMOP_HU, 0, rd, er, lat);
    check("lhu", rd, 32'h0000_DEAD);
    txn(0, 32'h8000_0004, 32'h0102_0304, MEMOP_W, 1, rd, er, lat);
    txn(0, 32'h8000_0006, 32'h9999_ABCD, MEMOP_H, 1, rd, er, lat);
    check("sh_err", 32'(er), 0);
    txn(0, 32'h8000_0004, 0, MEMOP_W, 0, rd, er, lat);
    check("sh_lw", rd, 32'hABCD_0304);
    txn(0, 32'h8000_0002, 0, MEMOP_W, 0, rd, er, lat);
    check("lw_mis_err", 32'(er), 1);
    check("lw_mis_rdata", rd, 0);
    txn(0, 32'h8000_0003, 32'h0000_7777, MEMOP_H, 1, rd, er, lat);
    check("sh_mis_err", 32'(er), 1);
    txn(0, 32'h8000_0000, 0, MEMOP_W, 0, rd, er, lat);
    check("after_err_lw", rd, 32'hDEAD_12EF);
    txn(0, 32'h7FFF_FFFC, 0, MEMOP_W, 0, rd, er, lat);
    check("below_base_err", 32'(er), 1);
    txn(0, 32'h8000_0000, 0, 3'b011, 0, rd, er, lat);
    check("bad_op_err", 32'(er), 1);
    check("bad_op_rdata", rd, 0);
    txn(0, 32'h8000_0000, 32'hFFFF_FFFF, MEMOP_BU, 1, rd, er, lat);
    check("sbu_err", 32'(er), 1);
    txn(0, 32'h8000_3FFC, 32'hCAFE_F00D, MEMOP_W, 1, rd, er, lat);
    check("top_sw_err", 32'(er), 0);
    txn(0, 32'h8000_3FFC, 0, MEMOP_W, 0, rd, er, lat);
    check("top_lw", rd, 32'hCAFE_F00D);
    txn(0, 32'h8000_4000, 0, MEMOP_W, 0, rd, er, lat);
    check("past_top_err", 32'(er), 1);
    txn(0, 32'h8000_0000, 0, MEMOP_W, 0, rd, er, lat);
    check("bad_store_nowrite", rd, 32'hDEAD_12EF);
    a = 32'h8000_0000; op = MEMOP_W; we = 1'b0; v2 = 1'b1;
    step();
    a = 32'h8000_0004;
    lat = 0;
    while (!bus.resp_valid && lat < 30) begin step(); lat++; end
    check("stall_lat", lat, 3);
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", 32'(bus.resp_valid), 1);
      check("stall_rdata", bus.resp_rdata, 32'hDEAD_12EF);
      check("stall_err", 32'(bus.resp_err), 0);
      check("stall_req_ready", 32'(bus.req_ready), 0);
      step();
    end
    rr2 = 1'b1;
    step();
    rr2 = 1'b0;
    check("hs_req_ready", 32'(bus.req_ready), 1);
    check("hs_resp_valid", 32'(bus.resp_valid), 0);
    step();
    v2 = 1'b0;
    check("second_accept", 32'(bus.req_ready), 0);
    lat = 0;
    while (!bus.resp_valid && lat < 30) begin step(); lat++; end
    check("second_lat", lat, 3);
    check("second_rdata", bus.resp_rdata, 32'hABCD_0304);
    rr2 = 1'b1;
    step();
    rr2 = 1'b0;
    txn(0, 32'h8000_0010, 32'h1122_3344, MEMOP_W, 1, rd, er, lat);
    a = 32'h8000_0010; wd = 32'h0000_0055; op = MEMOP_W; we = 1'b1; v2 = 1'b1;
    step();
    v2 = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_resp_valid", 32'(bus.resp_valid), 0);
    repeat (5) step();
    check("abort_no_resp", 32'(bus.resp_valid), 0);
    txn(0, 32'h8000_0010, 0, MEMOP_W, 0, rd, er, lat);
    check("abort_lw", rd, 32'h1122_3344);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
